// File: rtl/canny_pkg.sv
// Shared definitions for the Canny pipeline stages: clogb2 helper,
// 3x3 window element indices and the window generator state type.
package canny_pkg;

  // Smallest bit width able to index 0..v-1 (never below 1).
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} win_state_t;

endpackage

// File: rtl/window_3x3_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
interface window_3x3_if #(parameter int DATA_WIDTH = 16);
  logic                    clear;
  logic                    pix_vld;
  logic [DATA_WIDTH-1:0]   pix_in;
  logic [9*DATA_WIDTH-1:0] win_o;
  logic                    win_vld;
  logic                    done;

  modport master (output clear, pix_vld, pix_in,
                  input  win_o, win_vld, done);
  modport slave  (input  clear, pix_vld, pix_in,
                  output win_o, win_vld, done);
endinterface

// File: rtl/window_3x3_line_fifo.sv
// line_fifo: delay line of DEPTH accepted samples; q is the sample that
// entered DEPTH accepts ago.
module line_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Shift one position per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/window_3x3.sv
// window_3x3: sliding 3x3 window over a padded raster stream.
// Optional macro WINDOW_3X3_OVF_EN adds the sticky ovf_o flag that
// records a pixel dropped by a simultaneous clear.
//
// state | meaning
// FILL  | rows 0..1 loading the line buffers, no windows
// RUN   | rows 2..W-1, one window per pixel with col >= 2
module window_3x3
  import canny_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FMAP_SIZE  = 28,
  parameter int N          = 1
) (
  input  logic clk,
  input  logic rst_n,
  window_3x3_if.slave bus
`ifdef WINDOW_3X3_OVF_EN
  , output logic ovf_o
`endif
);

  localparam int W  = FMAP_SIZE + 2 * N;
  localparam int CW = clogb2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  win_state_t              state_q, state_d;
  logic [CW-1:0]           col_q, col_d, row_q, row_d;
  logic [DATA_WIDTH-1:0]   sh_q [3][3];
  logic [DATA_WIDTH-1:0]   sh_d [3][3];
  logic [9*DATA_WIDTH-1:0] win_q, win_d;
  logic                    vld_q, vld_d, done_q, done_d;
  logic [DATA_WIDTH-1:0]   lb0_q, lb1_q;
  logic                    accept, last_pix, emit;

  assign accept   = bus.pix_vld & ~bus.clear;
  assign last_pix = (row_q == LAST) && (col_q == LAST);
  assign emit     = accept && (state_q == RUN) && (col_q >= TWO);

  // lb0 yields the pixel one padded row above, lb1 two rows above.
  line_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(W)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en_i(accept), .d_i(bus.pix_in), .q_o(lb0_q)
  );
  line_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en_i(accept), .d_i(lb0_q), .q_o(lb1_q)
  );

  // Window array shifts left; new column enters at c=2, oldest line at r=0.
  always_comb begin
    sh_d = sh_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        sh_d[r][0] = sh_q[r][1];
        sh_d[r][1] = sh_q[r][2];
      end
      sh_d[0][2] = lb1_q;
      sh_d[1][2] = lb0_q;
      sh_d[2][2] = bus.pix_in;
    end
  end

  // Counters, FSM next state and registered window outputs.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    win_d   = win_q;
    if (bus.clear) begin
      state_d = FILL;
      col_d   = '0;
      row_d   = '0;
    end else if (bus.pix_vld) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (state_q == FILL) begin
        if (row_q == TWO) state_d = RUN;
      end else begin
        if (last_pix) state_d = FILL;
      end
      if (emit) begin
        vld_d  = 1'b1;
        done_d = last_pix;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            win_d[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = sh_d[r][c];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) sh_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      sh_q    <= sh_d;
    end
  end

  assign bus.win_o   = win_q;
  assign bus.win_vld = vld_q;
  assign bus.done    = done_q;

`ifdef WINDOW_3X3_OVF_EN
  logic ovf_q;

  // Sticky record of a pixel lost to a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (bus.pix_vld && bus.clear) ovf_q <= 1'b1;
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3 with FMAP_SIZE=4, N=1 (W=6).
module tb_window_3x3;
  import canny_pkg::*;

  localparam int DW = 16;
  localparam int WB = 9 * DW;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
`ifdef WINDOW_3X3_OVF_EN
  logic ovf_o;
`endif

  window_3x3_if #(.DATA_WIDTH(DW)) bus ();

  window_3x3 #(.DATA_WIDTH(DW), .FMAP_SIZE(4), .N(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef WINDOW_3X3_OVF_EN
    , .ovf_o(ovf_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] pack9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [WB-1:0] w;
    w = '0;
    w[0*DW +: DW] = 16'(e0); w[1*DW +: DW] = 16'(e1); w[2*DW +: DW] = 16'(e2);
    w[3*DW +: DW] = 16'(e3); w[4*DW +: DW] = 16'(e4); w[5*DW +: DW] = 16'(e5);
    w[6*DW +: DW] = 16'(e6); w[7*DW +: DW] = 16'(e7); w[8*DW +: DW] = 16'(e8);
    return w;
  endfunction

  // Window emitted after padded pixel (r,c): rows r-2..r, cols c-2..c.
  function automatic logic [WB-1:0] exp_win(input int base, input int r, input int c);
    logic [WB-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*DW +: DW] = 16'(base + (r - 2 + i) * 6 + (c - 2 + j));
    return w;
  endfunction

  task automatic push(input logic v, input logic [DW-1:0] d);
    bus.pix_vld = v;
    bus.pix_in  = d;
    @(posedge clk);
    #1;
  endtask

  // Streams one padded frame of value base+r*6+c; optional 3-cycle pause
  // before (pause_r,4) and optional abort before (abort_r,0).
  task automatic frame(input int base, input int pause_r, input int abort_r);
    int nwin, ndone;
    logic ev, ed;
    nwin = 0;
    ndone = 0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (r == abort_r && c == 0) return;
        if (r == pause_r && c == 4) begin
          repeat (3) begin
            push(1'b0, 16'hBEEF);
            chk("pause_vld", bus.win_vld, 0);
            chk("pause_hold", bus.win_o, exp_win(base, r, c - 1));
          end
        end
        push(1'b1, 16'(base + r * 6 + c));
        ev = (r >= 2) && (c >= 2);
        ed = (r == 5) && (c == 5);
        if (bus.win_vld) nwin++;
        if (bus.done) ndone++;
        chk("win_vld", bus.win_vld, ev);
        chk("done", bus.done, ed);
        if (ev) chk("win_data", bus.win_o, exp_win(base, r, c));
        if (r == 2 && c == 2)
          chk("first_win", bus.win_o, pack9(base+0, base+1, base+2, base+6, base+7,
                                            base+8, base+12, base+13, base+14));
        if (ed)
          chk("last_win", bus.win_o, pack9(base+21, base+22, base+23, base+27, base+28,
                                           base+29, base+33, base+34, base+35));
      end
    end
    chk("win_count", nwin, 16);
    chk("done_count", ndone, 1);
  endtask

  initial begin
    logic [WB-1:0] tl;
    rst_n       = 1'b0;
    bus.clear   = 1'b0;
    bus.pix_vld = 1'b0;
    bus.pix_in  = '0;
    #12;
    chk("rst_win", bus.win_o, 0);
    chk("rst_vld", bus.win_vld, 0);
    chk("rst_done", bus.done, 0);
`ifdef WINDOW_3X3_OVF_EN
    chk("rst_ovf", ovf_o, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two frames back to back, then a frame with a pause.
    frame(0, -1, -1);
    frame(100, -1, -1);
    tl = bus.win_o;
    chk("win_tl_elem", tl[WIN_TL*DW +: DW], 100 + 21);
    frame(150, 3, -1);

    // Clear at the start of row 3, with pix_vld high so the pixel is dropped.
    frame(200, -1, 3);
    bus.clear = 1'b1;
    push(1'b1, 16'hDEAD);
    bus.clear = 1'b0;
    chk("clr_vld", bus.win_vld, 0);
    chk("clr_done", bus.done, 0);
`ifdef WINDOW_3X3_OVF_EN
    chk("ovf_set", ovf_o, 1);
`endif
    frame(300, -1, -1);
`ifdef WINDOW_3X3_OVF_EN
    chk("ovf_sticky", ovf_o, 1);
`endif

    // Mid-frame asynchronous reset right after a window was emitted.
    frame(400, -1, 4);
    chk("pre_rst_vld", bus.win_vld, 1);
    bus.pix_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_win", bus.win_o, 0);
    chk("arst_vld", bus.win_vld, 0);
    chk("arst_done", bus.done, 0);
`ifdef WINDOW_3X3_OVF_EN
    chk("arst_ovf", ovf_o, 0);
`endif
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(500, -1, -1);

    bus.pix_vld = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
